// File: rtl/output_sram_drain.sv
// output_sram_drain: streams output SRAM words 0..last_addr out on a valid/ready port via a prefetch FIFO
module output_sram_drain #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] last_addr,
    output logic [ADDR_WIDTH-1:0] drain_sram_read_address,
    input  logic [DATA_WIDTH-1:0] sram_drain_read_data,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  done
);
    localparam int IW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   last_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [ADDR_WIDTH:0]     rd_ptr;
    logic [ADDR_WIDTH:0]     out_cnt;
    logic                    inflight;
    logic [DATA_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];
    logic [IW-1:0]           head, tail;
    logic [CW-1:0]           count;
    logic                    issue, push, pop;

    assign push                    = inflight;
    assign pop                     = m_valid & m_ready;
    assign m_valid                 = (count != '0);
    assign m_data                  = m_valid ? fifo_mem[head] : '0;
    assign m_last                  = m_valid & (out_cnt == {1'b0, last_q});
    assign drain_sram_read_address = issue ? rd_ptr[ADDR_WIDTH-1:0] : addr_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state: leave READ on the last issue, finish on the final handshake
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = start ? READ : IDLE;
            READ:    state_next = (issue && rd_ptr == {1'b0, last_q}) ? DRAIN : READ;
            DRAIN:   state_next = ((pop && m_last) ||
                                   (count == '0 && !inflight && out_cnt > {1'b0, last_q})) ? FIN : DRAIN;
            default: state_next = IDLE;
        endcase
    end

    // Outputs: issue only while the FIFO plus the read in flight leaves a free slot
    always_comb begin
        issue = (state == READ) &&
                (({1'b0, count} + (CW+1)'(inflight)) < (CW+1)'(FIFO_DEPTH));
        busy  = (state == READ) || (state == DRAIN);
        done  = (state == FIN);
    end

    // Read pointer, output counter, in-flight tracking and FIFO occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q   <= '0;
            addr_q   <= '0;
            rd_ptr   <= '0;
            out_cnt  <= '0;
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            if (state == IDLE && start) begin
                last_q  <= last_addr;
                rd_ptr  <= '0;
                out_cnt <= '0;
            end
            if (issue) begin
                addr_q <= rd_ptr[ADDR_WIDTH-1:0];
                rd_ptr <= rd_ptr + 1'b1;
            end
            inflight <= issue;
            if (push) tail <= (tail == IW'(FIFO_DEPTH - 1)) ? '0 : tail + 1'b1;
            if (pop) begin
                head    <= (head == IW'(FIFO_DEPTH - 1)) ? '0 : head + 1'b1;
                out_cnt <= out_cnt + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage: capture the SRAM word one cycle after its address was issued
    always_ff @(posedge clk) begin
        if (push) fifo_mem[tail] <= sram_drain_read_data;
    end
endmodule

// File: tb/tb_output_sram_drain.sv
// tb_output_sram_drain: directed scenario checks for the output SRAM drain stage
module tb_output_sram_drain;
    logic        clk = 1'b0;
    logic        reset, start, m_ready;
    logic [11:0] last_addr, addr;
    logic [15:0] rdata, m_data;
    logic        m_valid, m_last, busy, done;

    logic [15:0] mem [0:4095];
    logic [15:0] got [0:4095];
    int          acc_k [0:4095];

    int n_cmp = 0, n_bad = 0;
    int nwords, last_cnt, last_idx, first_valid, done_k, addr1;
    int unstable, ahead, busy_gap, timeout, post_done_bad;

    output_sram_drain dut (
        .clk(clk), .reset(reset), .start(start), .last_addr(last_addr),
        .drain_sram_read_address(addr), .sram_drain_read_data(rdata),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // SRAM model: one cycle read latency, no enable
    always @(posedge clk) rdata <= mem[addr];

    // Runs one drain; mode 0 = m_ready always high, mode 1 = alternating plus a 10-cycle low window
    task automatic drain(input logic [11:0] la, input int mode, input int pulse_at);
        logic        pv, pr, pl, fin, pulsed;
        logic [15:0] pd;
        int          k, budget;
        nwords = 0; last_cnt = 0; last_idx = -1; first_valid = -1; done_k = -1; addr1 = -1;
        unstable = 0; ahead = 0; busy_gap = 0; timeout = 0; post_done_bad = 0;
        pv = 0; pr = 1; pd = '0; pl = 0; fin = 0; pulsed = 0;
        budget = 3 * (int'(la) + 1) + 60;
        @(posedge clk); #1;
        last_addr = la; start = 1'b1; m_ready = 1'b1; k = 0;
        while (!fin && k < budget) begin
            @(posedge clk); #1;
            start = 1'b0;
            k++;
            m_ready = (mode == 0) ? 1'b1 : ((k % 2 == 1) && !(k >= 12 && k < 22));
            if (pulse_at >= 0 && nwords == pulse_at && !pulsed) begin
                start = 1'b1; last_addr = 12'h003; pulsed = 1;
            end
            @(negedge clk);
            if (k == 1) addr1 = int'(addr);
            if (pv && !pr && (!m_valid || m_data !== pd || m_last !== pl)) unstable++;
            if (busy && int'(addr) - nwords > 4) ahead++;
            if (m_valid && first_valid < 0) first_valid = k;
            if (m_valid && m_ready) begin
                got[nwords]   = m_data;
                acc_k[nwords] = k;
                if (m_last) begin last_cnt++; last_idx = nwords; end
                nwords++;
            end
            if (done) begin
                done_k = k; fin = 1;
                if (busy) busy_gap++;
            end else if (!busy) busy_gap++;
            pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
        end
        if (!fin) timeout = 1;
        @(posedge clk); #1;
        m_ready = 1'b1; start = 1'b0;
        @(negedge clk);
        if (done || busy || m_valid) post_done_bad = 1;
    endtask

    task automatic test_reset();
        int stray;
        int errs;
        reset = 1'b1; start = 1'b0; m_ready = 1'b1; last_addr = '0;
        for (int i = 0; i < 4096; i++) mem[i] = 16'(3 * i);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", m_valid); end
        n_cmp++; if (m_last !== 1'b0) begin n_bad++; $display("FAIL rst_last: got %b want 0", m_last); end
        n_cmp++; if (m_data !== 16'h0) begin n_bad++; $display("FAIL rst_data: got %h want 0", m_data); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", done); end
        n_cmp++; if (addr !== 12'h0) begin n_bad++; $display("FAIL rst_addr: got %h want 0", addr); end
        // Mid-stream reset with reads in flight
        @(posedge clk); #1 start = 1'b1; last_addr = 12'h01F;
        @(posedge clk); #1 start = 1'b0;
        repeat (6) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== 16'h0)
            begin n_bad++; $display("FAIL midrst_stream: got v=%b l=%b d=%h want 0 0 0", m_valid, m_last, m_data); end
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || addr !== 12'h0)
            begin n_bad++; $display("FAIL midrst_ctrl: got busy=%b done=%b addr=%h want 0 0 0", busy, done, addr); end
        @(posedge clk); #1 reset = 1'b0;
        stray = 0;
        repeat (3) begin
            @(negedge clk);
            if (m_valid || busy) stray++;
        end
        n_cmp++; if (stray !== 0) begin n_bad++; $display("FAIL midrst_discard: got %0d stray cycles want 0", stray); end
        // Restart after reset begins again at address 0
        drain(12'h007, 0, -1);
        errs = 0;
        for (int i = 0; i < nwords && i < 8; i++) if (got[i] !== 16'(3 * i)) errs++;
        n_cmp++; if (addr1 !== 0) begin n_bad++; $display("FAIL restart_addr: got %0d want 0", addr1); end
        n_cmp++; if (nwords !== 8) begin n_bad++; $display("FAIL restart_count: got %0d want 8", nwords); end
        n_cmp++; if (errs !== 0) begin n_bad++; $display("FAIL restart_words: got %0d bad want 0", errs); end
    endtask

    task automatic test_full_rate();
        int errs, terrs;
        for (int i = 0; i < 4096; i++) mem[i] = 16'(3 * i);
        drain(12'h01F, 0, -1);
        errs = 0; terrs = 0;
        for (int i = 0; i < nwords && i < 32; i++) begin
            if (got[i] !== 16'(3 * i)) errs++;
            if (acc_k[i] !== 3 + i) terrs++;
        end
        n_cmp++; if (timeout !== 0) begin n_bad++; $display("FAIL full_timeout: got %0d want 0", timeout); end
        n_cmp++; if (addr1 !== 0) begin n_bad++; $display("FAIL full_addr1: got %0d want 0", addr1); end
        n_cmp++; if (first_valid !== 3) begin n_bad++; $display("FAIL full_first_valid: got %0d want 3", first_valid); end
        n_cmp++; if (nwords !== 32) begin n_bad++; $display("FAIL full_count: got %0d want 32", nwords); end
        n_cmp++; if (errs !== 0) begin n_bad++; $display("FAIL full_words: got %0d bad want 0", errs); end
        n_cmp++; if (terrs !== 0) begin n_bad++; $display("FAIL full_timing: got %0d late want 0", terrs); end
        n_cmp++; if (last_cnt !== 1 || last_idx !== 31) begin n_bad++; $display("FAIL full_last: got cnt=%0d idx=%0d want 1 31", last_cnt, last_idx); end
        n_cmp++; if (done_k !== 35) begin n_bad++; $display("FAIL full_done_cycle: got %0d want 35", done_k); end
        n_cmp++; if (busy_gap !== 0) begin n_bad++; $display("FAIL full_busy: got %0d bad cycles want 0", busy_gap); end
        n_cmp++; if (post_done_bad !== 0) begin n_bad++; $display("FAIL full_done_pulse: got %0d want 0", post_done_bad); end
    endtask

    task automatic test_backpressure();
        int errs;
        for (int i = 0; i < 4096; i++) mem[i] = 16'(3 * i);
        drain(12'h01F, 1, -1);
        errs = 0;
        for (int i = 0; i < nwords && i < 32; i++) if (got[i] !== 16'(3 * i)) errs++;
        n_cmp++; if (timeout !== 0) begin n_bad++; $display("FAIL bp_timeout: got %0d want 0", timeout); end
        n_cmp++; if (nwords !== 32) begin n_bad++; $display("FAIL bp_count: got %0d want 32", nwords); end
        n_cmp++; if (errs !== 0) begin n_bad++; $display("FAIL bp_words: got %0d bad want 0", errs); end
        n_cmp++; if (unstable !== 0) begin n_bad++; $display("FAIL bp_stable: got %0d changes want 0", unstable); end
        n_cmp++; if (ahead !== 0) begin n_bad++; $display("FAIL bp_ahead: got %0d cycles want 0", ahead); end
        n_cmp++; if (last_cnt !== 1 || last_idx !== 31) begin n_bad++; $display("FAIL bp_last: got cnt=%0d idx=%0d want 1 31", last_cnt, last_idx); end
        n_cmp++; if (done_k !== acc_k[31] + 1) begin n_bad++; $display("FAIL bp_done: got %0d want %0d", done_k, acc_k[31] + 1); end
    endtask

    task automatic test_single();
        for (int i = 0; i < 4096; i++) mem[i] = 16'(16'hA5A0 + i);
        drain(12'h000, 0, -1);
        n_cmp++; if (nwords !== 1) begin n_bad++; $display("FAIL single_count: got %0d want 1", nwords); end
        n_cmp++; if (got[0] !== 16'hA5A0) begin n_bad++; $display("FAIL single_word: got %h want a5a0", got[0]); end
        n_cmp++; if (last_cnt !== 1 || last_idx !== 0) begin n_bad++; $display("FAIL single_last: got cnt=%0d idx=%0d want 1 0", last_cnt, last_idx); end
        n_cmp++; if (done_k !== 4 || acc_k[0] !== 3) begin n_bad++; $display("FAIL single_done: got done=%0d acc=%0d want 4 3", done_k, acc_k[0]); end
    endtask

    task automatic test_start_ignored();
        int errs;
        for (int i = 0; i < 4096; i++) mem[i] = 16'(3 * i);
        drain(12'h01F, 0, 5);
        errs = 0;
        for (int i = 0; i < nwords && i < 32; i++) if (got[i] !== 16'(3 * i)) errs++;
        n_cmp++; if (nwords !== 32) begin n_bad++; $display("FAIL ign_count: got %0d want 32", nwords); end
        n_cmp++; if (errs !== 0) begin n_bad++; $display("FAIL ign_words: got %0d bad want 0", errs); end
        n_cmp++; if (last_idx !== 31) begin n_bad++; $display("FAIL ign_last: got %0d want 31", last_idx); end
        n_cmp++; if (busy_gap !== 0) begin n_bad++; $display("FAIL ign_busy: got %0d bad cycles want 0", busy_gap); end
        n_cmp++; if (done_k !== 35) begin n_bad++; $display("FAIL ign_done: got %0d want 35", done_k); end
    endtask

    task automatic test_max();
        int errs;
        for (int i = 0; i < 4096; i++) mem[i] = 16'(i);
        drain(12'hFFF, 0, -1);
        errs = 0;
        for (int i = 0; i < nwords && i < 4096; i++) if (got[i] !== 16'(i)) errs++;
        n_cmp++; if (timeout !== 0) begin n_bad++; $display("FAIL max_timeout: got %0d want 0", timeout); end
        n_cmp++; if (nwords !== 4096) begin n_bad++; $display("FAIL max_count: got %0d want 4096", nwords); end
        n_cmp++; if (errs !== 0) begin n_bad++; $display("FAIL max_words: got %0d bad want 0", errs); end
        n_cmp++; if (last_cnt !== 1 || last_idx !== 4095) begin n_bad++; $display("FAIL max_last: got cnt=%0d idx=%0d want 1 4095", last_cnt, last_idx); end
        n_cmp++; if (done_k !== 4099) begin n_bad++; $display("FAIL max_done: got %0d want 4099", done_k); end
    endtask

    initial begin
        test_reset();
        test_full_rate();
        test_backpressure();
        test_single();
        test_start_ignored();
        test_max();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
